// File: rtl/vga_fetch_pkg.sv
`default_nettype none
// ============================================================================
// vga_fetch_pkg : shared constants, FSM state type and bank addressing helper
// Revision      : 1.0
// ============================================================================
package vga_fetch_pkg;

  localparam int H_VIS       = 640;
  localparam int V_VIS       = 480;
  localparam int V_TOT       = 525;
  localparam int FRAME_WORDS = 307200;
  localparam int BANK_DEPTH  = 2 * H_VIS;
  localparam int BANK_AW     = $clog2(BANK_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_t;

  // Banks are packed back to back so the RAM stays exactly two lines deep.
  function automatic logic [BANK_AW-1:0] bank_index(input logic bank, input logic [9:0] idx);
    return bank ? (BANK_AW'(idx) + BANK_AW'(H_VIS)) : BANK_AW'(idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_line_fetcher_line_buffer_ram.sv
`default_nettype none
// ============================================================================
// line_buffer_ram : simple dual-port RAM, sync write, registered sync read
// Revision        : 1.0
// ============================================================================
module line_buffer_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1280,
  parameter int AW     = 11
) (
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the block maps onto embedded RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// vga_line_fetcher : ping-pong scanline prefetcher between SDRAM burst master
//                    and VGA output. Optional macro: VGA_LINE_UNDERRUN_EN.
// Revision         : 1.0
// ============================================================================
module vga_line_fetcher
  import vga_fetch_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              burst_finished,
  output logic              burst_req,
  output logic [ADDR_W-1:0] burst_address,
  output logic [DATA_W-1:0] pixel_data,
  output logic              line_done,
  output logic              underrun
);

  fetch_state_t      state, state_nx;
  logic [9:0]        last_y;
  logic [9:0]        tgt;
  logic [9:0]        issue_line;
  logic [9:0]        pend_line;
  logic [9:0]        wptr;
  logic [9:0]        rd_x;
  logic              pend;
  logic              fill_bank;
  logic              trig, keep, issue, finishing, wr_en;
  logic              pix_vis;
  logic              line_bad_now;
  logic [DATA_W-1:0] rd_data;

  assign trig       = (DrawY != last_y);
  assign tgt        = (DrawY == 10'(V_TOT - 1)) ? 10'd0 : DrawY + 10'd1;
  assign keep       = trig && (tgt < 10'(V_VIS));
  // A fresh trigger in IDLE issues immediately and takes priority over a stale pend.
  assign issue      = (state == ST_IDLE) && (pend || keep);
  assign issue_line = keep ? tgt : pend_line;
  assign finishing  = (state == ST_REQ) && burst_finished;
  assign wr_en      = (state == ST_REQ) && mem_ready && (wptr < 10'(H_VIS));
  assign rd_x       = (DrawX < 10'(H_VIS)) ? DrawX : 10'd0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    burst_req = 1'b0;
    case (state)
      ST_IDLE: if (pend || keep) state_nx = ST_REQ;
      ST_REQ: begin
        burst_req = 1'b1;
        if (burst_finished) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_y        <= '0;
      pend          <= 1'b0;
      pend_line     <= '0;
      burst_address <= '0;
      fill_bank     <= 1'b0;
      wptr          <= '0;
      line_done     <= 1'b0;
      pix_vis       <= 1'b0;
    end else begin
      last_y    <= DrawY;
      line_done <= finishing;
      pix_vis   <= (DrawX < 10'(H_VIS)) && (DrawY < 10'(V_VIS)) && !line_bad_now;
      if (issue) begin
        pend          <= 1'b0;
        burst_address <= frame_base + ADDR_W'(issue_line) * ADDR_W'(H_VIS);
        fill_bank     <= issue_line[0];
        wptr          <= '0;
      end else if (keep) begin
        pend      <= 1'b1;
        pend_line <= tgt;
      end
      if (wr_en) wptr <= wptr + 10'd1;
    end
  end

`ifdef VGA_LINE_UNDERRUN_EN
  logic [1:0] bank_valid;
  logic       line_bad;
  logic       underrun_r;

  // The verdict for a line is taken on its first cycle and held for the whole line.
  assign line_bad_now = trig ? ((DrawY < 10'(V_VIS)) && !bank_valid[DrawY[0]]) : line_bad;
  assign underrun     = underrun_r;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bank_valid <= '0;
      line_bad   <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (issue)     bank_valid[issue_line[0]] <= 1'b0;
      if (finishing) bank_valid[fill_bank]     <= 1'b1;
      line_bad <= line_bad_now;
      if (trig && line_bad_now) underrun_r <= 1'b1;
    end
  end
`else
  assign line_bad_now = 1'b0;
  assign underrun     = 1'b0;
`endif

  assign pixel_data = pix_vis ? rd_data : '0;

  line_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (BANK_DEPTH),
    .AW     (BANK_AW)
  ) u_ram (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .wr_addr (bank_index(fill_bank, wptr)),
    .wr_data (mem_data),
    .rd_addr (bank_index(DrawY[0], rd_x)),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// tb_vga_line_fetcher : randomized self-checking bench with a line-level model
// Revision            : 1.0
// ============================================================================
module tb_vga_line_fetcher;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
`ifdef VGA_LINE_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [ADDR_W-1:0] frame_base = '0;
  logic [9:0]        DrawX = '0;
  logic [9:0]        DrawY = '0;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              burst_finished = 1'b0;
  logic              burst_req;
  logic [ADDR_W-1:0] burst_address;
  logic [DATA_W-1:0] pixel_data;
  logic              line_done;
  logic              underrun;

  vga_line_fetcher #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .frame_base(frame_base), .DrawX(DrawX), .DrawY(DrawY),
    .mem_ready(mem_ready), .mem_data(mem_data), .burst_finished(burst_finished),
    .burst_req(burst_req), .burst_address(burst_address), .pixel_data(pixel_data),
    .line_done(line_done), .underrun(underrun)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: line banks as plain arrays plus the request bookkeeping.
  logic [DATA_W-1:0] m_mem [0:1][0:639];
  bit                m_valid [0:1];
  bit                m_busy, m_pend, m_underrun, m_line_bad;
  int                m_pend_line, m_bank, m_wcnt, m_prev_y;
  logic [ADDR_W-1:0] m_addr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input int t);
    longint a;
    a = longint'(frame_base) + longint'(t) * 640;
    m_addr  = ADDR_W'(a);
    m_busy  = 1'b1;
    m_bank  = t % 2;
    m_wcnt  = 0;
    m_valid[t % 2] = 1'b0;
  endtask

  task automatic apply_line(input int y);
    int t;
    if (y != m_prev_y) begin
      m_line_bad = UR_EN && (y < 480) && !m_valid[y % 2];
      if (m_line_bad) m_underrun = 1'b1;
      t = (y + 1) % 525;
      if (t < 480) begin
        if (m_busy) begin
          m_pend      = 1'b1;
          m_pend_line = t;
        end else begin
          issue(t);
        end
      end
    end
    m_prev_y = y;
  endtask

  task automatic set_line(input int y);
    DrawY = 10'(y);
    apply_line(y);
    step();
    check("burst_req", burst_req, m_busy);
    if (m_busy) check("burst_address", burst_address, m_addr);
    check("underrun", underrun, m_underrun);
  endtask

  task automatic feed_words(input int n, input bit fin);
    int gap;
    bit last;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check("req_hold", burst_req, 1);
      end
      last           = fin && (i == n - 1);
      mem_data       = $urandom;
      mem_ready      = 1'b1;
      burst_finished = last;
      if (m_wcnt < 640) begin
        m_mem[m_bank][m_wcnt] = mem_data;
        m_wcnt++;
      end
      step();
      mem_ready      = 1'b0;
      burst_finished = 1'b0;
      if (!last) check("req_hold", burst_req, 1);
    end
    if (fin) begin
      m_busy = 1'b0;
      m_valid[m_bank] = 1'b1;
      check("req_drop", burst_req, 0);
      check("line_done", line_done, 1);
      if (m_pend) begin
        m_pend = 1'b0;
        issue(m_pend_line);
      end
      step();
      check("line_done_pulse", line_done, 0);
      check("req_next", burst_req, m_busy);
      if (m_busy) check("addr_next", burst_address, m_addr);
    end
  endtask

  task automatic check_pixels(input int n);
    int x;
    logic [DATA_W-1:0] exp;
    for (int k = 0; k < n; k++) begin
      x = (k % 4 == 3) ? $urandom_range(640, 799) : $urandom_range(0, 639);
      DrawX = 10'(x);
      step();
      exp = (x < 640 && int'(DrawY) < 480 && !m_line_bad) ? m_mem[DrawY[0]][x] : '0;
      check("pixel_data", pixel_data, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_burst_req", burst_req, 0);
    check("rst_burst_address", burst_address, 0);
    check("rst_pixel_data", pixel_data, 0);
    check("rst_line_done", line_done, 0);
    check("rst_underrun", underrun, 0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_underrun = 0; m_line_bad = 0;
    m_prev_y = 0; m_valid[0] = 0; m_valid[1] = 0;
  endtask

  initial begin
    model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 640; i++) m_mem[b][i] = '0;
    frame_base = 25'h1FFFE00;   // line 1 wraps past 2^ADDR_W
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs();
    @(negedge Clk) Reset = 1'b0;

    // First frame start: trigger for line 0 from DrawY=524
    set_line(524);
    check("first_addr_is_base", burst_address, 25'h1FFFE00);
    feed_words(640, 1);
    set_line(0);
    feed_words(641, 1);          // extra word beyond 640 must be discarded
    check_pixels(8);

    // Mid-frame lines with a new base; line 11 lands in bank 1
    frame_base = 25'd1000;
    set_line(9);
    feed_words(640, 1);
    set_line(10);
    check("addr_line11", burst_address, 25'd8040);
    feed_words(640, 1);
    set_line(11);
    feed_words(640, 1);
    check_pixels(8);

    // Bottom of the visible area
    set_line(478);
    feed_words(640, 1);
    set_line(479);
    set_line(480);
    check_pixels(4);
    set_line(523);

    // Late burst: display reaches line 0 before it completes, trigger queued in REQ
    set_line(524);
    feed_words(200, 0);
    set_line(0);
    check_pixels(6);
    feed_words(440, 1);
    check_pixels(6);
    feed_words(640, 1);

    // Reset in the middle of a burst
    set_line(1);
    feed_words(300, 0);
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge Clk) Reset = 1'b0;
    apply_line(1);
    step();
    check("restart_req", burst_req, m_busy);
    check("restart_addr", burst_address, m_addr);
    check("restart_underrun", underrun, m_underrun);
    feed_words(640, 1);
    set_line(2);
    feed_words(640, 1);
    check_pixels(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
